// File: rtl/font_mem_writer_pkg.sv
// Shared definitions for the font memory writer: FSM encoding, default sheet
// geometry and a small width helper used by the writer and the tile address helper.
package font_mem_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PX_ADDR_BITS_DEF  = 13;
  localparam int PX_DATA_BITS_DEF  = 12;
  localparam int ALPHABET_BITS_DEF = 8;
  localparam int FONT_WIDTH_DEF    = 8;
  localparam int FONT_HEIGHT_DEF   = 8;
  localparam int FONT_NUM_ROW_DEF  = 8;
  localparam int FONT_NUM_COL_DEF  = 16;
  localparam int FONT_TOTAL_PX     = FONT_WIDTH_DEF * FONT_HEIGHT_DEF *
                                     FONT_NUM_COL_DEF * FONT_NUM_ROW_DEF;

  // Counter width that never collapses to zero bits for 1-pixel dimensions.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/font_tile_addr.sv
// Combinational glyph/pixel to font RAM address mapping for the tiled sheet.
// Shared with the read side so both ends agree on where a pixel lives.
module font_tile_addr
  import font_mem_writer_pkg::*;
#(
  parameter int PX_ADDR_BITS_N  = PX_ADDR_BITS_DEF,
  parameter int ALPHABET_BITS_N = ALPHABET_BITS_DEF,
  parameter int FONT_WIDTH_CNT  = FONT_WIDTH_DEF,
  parameter int FONT_HEIGHT_CNT = FONT_HEIGHT_DEF,
  parameter int FONT_NUM_ROW    = FONT_NUM_ROW_DEF,
  parameter int FONT_NUM_COL    = FONT_NUM_COL_DEF,
  localparam int XW = clog2_min1(FONT_WIDTH_CNT),
  localparam int YW = clog2_min1(FONT_HEIGHT_CNT)
) (
  input  logic [ALPHABET_BITS_N-1:0] alphabet,
  input  logic [XW-1:0]              x,
  input  logic [YW-1:0]              y,
  output logic [PX_ADDR_BITS_N-1:0]  addr
);

  localparam int AW = PX_ADDR_BITS_N;
  localparam logic [ALPHABET_BITS_N-1:0] NCOL_A = ALPHABET_BITS_N'(FONT_NUM_COL);
  localparam logic [ALPHABET_BITS_N-1:0] NROW_A = ALPHABET_BITS_N'(FONT_NUM_ROW);
  localparam logic [AW-1:0] W_A  = AW'(FONT_WIDTH_CNT);
  localparam logic [AW-1:0] H_A  = AW'(FONT_HEIGHT_CNT);
  localparam logic [AW-1:0] WN_A = AW'(FONT_WIDTH_CNT * FONT_NUM_COL);

  logic [ALPHABET_BITS_N-1:0] bc;
  logic [ALPHABET_BITS_N-1:0] br;

  // Codes beyond the sheet wrap onto the row index rather than overflowing.
  always_comb begin
    bc   = alphabet % NCOL_A;
    br   = (alphabet / NCOL_A) % NROW_A;
    addr = (AW'(x) + W_A * AW'(bc)) + WN_A * (AW'(y) + H_A * AW'(br));
  end

endmodule

// File: rtl/font_mem_writer.sv
// Writes one streamed glyph bitmap into the font RAM at its tiled location,
// or fills the whole RAM with a constant word.
module font_mem_writer
  import font_mem_writer_pkg::*;
#(
  parameter int PX_ADDR_BITS_N  = PX_ADDR_BITS_DEF,
  parameter int PX_DATA_BITS_N  = PX_DATA_BITS_DEF,
  parameter int FONT_WIDTH_CNT  = FONT_WIDTH_DEF,
  parameter int FONT_HEIGHT_CNT = FONT_HEIGHT_DEF,
  parameter int FONT_NUM_ROW    = FONT_NUM_ROW_DEF,
  parameter int FONT_NUM_COL    = FONT_NUM_COL_DEF,
  parameter int ALPHABET_BITS_N = ALPHABET_BITS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic [ALPHABET_BITS_N-1:0] alphabet,
  input  logic                       clr_start,
  input  logic [PX_DATA_BITS_N-1:0]  clr_value,
  input  logic                       px_valid,
  input  logic [PX_DATA_BITS_N-1:0]  px_data,
  output logic                       px_ready,
  output logic                       mem_we,
  output logic [PX_ADDR_BITS_N-1:0]  mem_addr,
  output logic [PX_DATA_BITS_N-1:0]  mem_din,
  output logic                       busy,
  output logic                       done,
  output state_t                     fsm_state
);

  // Pixel stream handshake: a pixel transfers on a rising clk edge where
  // px_valid && px_ready; px_ready depends only on the state, never on px_valid.

  localparam int AW    = PX_ADDR_BITS_N;
  localparam int XW    = clog2_min1(FONT_WIDTH_CNT);
  localparam int YW    = clog2_min1(FONT_HEIGHT_CNT);
  localparam int TOTAL = FONT_WIDTH_CNT * FONT_HEIGHT_CNT * FONT_NUM_COL * FONT_NUM_ROW;

  localparam logic [XW-1:0] X_LAST   = XW'(FONT_WIDTH_CNT - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(FONT_HEIGHT_CNT - 1);
  localparam logic [AW-1:0] CLR_LAST = AW'(TOTAL - 1);

  state_t state;
  state_t state_nx;

  logic [XW-1:0]              x;
  logic [YW-1:0]              y;
  logic [AW-1:0]              clr_cnt;
  logic [ALPHABET_BITS_N-1:0] glyph;
  logic [PX_DATA_BITS_N-1:0]  fill;
  logic [AW-1:0]              tile_addr;
  logic                       xfer;

  font_tile_addr #(
    .PX_ADDR_BITS_N (PX_ADDR_BITS_N),
    .ALPHABET_BITS_N(ALPHABET_BITS_N),
    .FONT_WIDTH_CNT (FONT_WIDTH_CNT),
    .FONT_HEIGHT_CNT(FONT_HEIGHT_CNT),
    .FONT_NUM_ROW   (FONT_NUM_ROW),
    .FONT_NUM_COL   (FONT_NUM_COL)
  ) u_tile_addr (
    .alphabet(glyph),
    .x       (x),
    .y       (y),
    .addr    (tile_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (clr_start)       state_nx = ST_CLEAR;
        else if (load_start) state_nx = ST_LOAD;
      end
      ST_LOAD:  if (xfer && x == X_LAST && y == Y_LAST) state_nx = ST_DONE;
      ST_CLEAR: if (clr_cnt == CLR_LAST)                state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    px_ready  = (state == ST_LOAD);
    busy      = (state == ST_LOAD) || (state == ST_CLEAR);
    xfer      = px_ready && px_valid;
    fsm_state = state;
  end

  // Write port is registered: each accepted pixel or clear step appears one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      clr_cnt  <= '0;
      glyph    <= '0;
      fill     <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      done     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          x       <= '0;
          y       <= '0;
          clr_cnt <= '0;
          if (clr_start)       fill  <= clr_value;
          else if (load_start) glyph <= alphabet;
        end
        ST_LOAD: begin
          if (xfer) begin
            mem_we   <= 1'b1;
            mem_addr <= tile_addr;
            mem_din  <= px_data;
            if (x == X_LAST) begin
              x <= '0;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          mem_we   <= 1'b1;
          mem_addr <= clr_cnt;
          mem_din  <= fill;
          clr_cnt  <= clr_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_font_mem_writer.sv
// Directed bench for font_mem_writer: behavioural write model with an expected
// queue checked every cycle, plus hand-computed expectations per scenario.
module tb_font_mem_writer;
  import font_mem_writer_pkg::*;

  localparam int W     = 8;
  localparam int H     = 8;
  localparam int NCOL  = 16;
  localparam int NROW  = 8;
  localparam int TOTAL = W * H * NCOL * NROW;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [7:0]  alphabet;
  logic        clr_start;
  logic [11:0] clr_value;
  logic        px_valid;
  logic [11:0] px_data;
  logic        px_ready;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [11:0] mem_din;
  logic        busy;
  logic        done;
  state_t      fsm_state;

  font_mem_writer dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .alphabet  (alphabet),
    .clr_start (clr_start),
    .clr_value (clr_value),
    .px_valid  (px_valid),
    .px_data   (px_data),
    .px_ready  (px_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // behavioural model: mode 0 idle, 1 load, 2 clear, 3 done
  function automatic int glyph_addr(input int code, input int idx);
    int px = idx % W;
    int py = idx / W;
    int bc = code % NCOL;
    int br = (code / NCOL) % NROW;
    return (px + W * bc) + W * NCOL * (py + H * br);
  endfunction

  logic [24:0] exp_q[$];
  logic [24:0] exp_w;
  int          m_mode  = 0;
  int          m_idx   = 0;
  int          m_alpha = 0;
  logic [11:0] m_val   = '0;
  logic        e_done  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
      m_idx  = 0;
      e_done = 1'b0;
      exp_q.delete();
    end else begin
      e_done = (m_mode == 3);
      case (m_mode)
        0: begin
          if (clr_start) begin
            m_mode = 2; m_idx = 0; m_val = clr_value;
          end else if (load_start) begin
            m_mode = 1; m_idx = 0; m_alpha = int'(alphabet);
          end
        end
        1: if (px_valid) begin
          exp_q.push_back({13'(glyph_addr(m_alpha, m_idx)), px_data});
          m_idx++;
          if (m_idx == W * H) m_mode = 3;
        end
        2: begin
          exp_q.push_back({13'(m_idx), m_val});
          m_idx++;
          if (m_idx == TOTAL) m_mode = 3;
        end
        default: m_mode = 0;
      endcase
    end
  end

  // scoreboard / monitor
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          wr_cnt = 0;
  int          last_we_cyc = -1;
  int          done_cyc = -1;
  logic [12:0] first_addr, last_addr;
  logic [11:0] first_data, last_data;
  logic [12:0] wr_addrs[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, (m_mode == 1 || m_mode == 2));
      check("px_ready", px_ready, (m_mode == 1));
      check("done", done, e_done);
      check("mem_we", mem_we, (exp_q.size() != 0));
      if (mem_we && exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("mem_addr", mem_addr, exp_w[24:12]);
        check("mem_din", mem_din, exp_w[11:0]);
      end
    end
    if (mem_we) begin
      wr_cnt++;
      if (wr_cnt == 1) begin
        first_addr = mem_addr;
        first_data = mem_din;
      end
      last_addr   = mem_addr;
      last_data   = mem_din;
      last_we_cyc = cyc;
      wr_addrs.push_back(mem_addr);
    end
    if (done) done_cyc = cyc;
  end

  // driver tasks
  task automatic reset_mon();
    wr_cnt = 0;
    done_cyc = -1;
    last_we_cyc = -1;
    wr_addrs.delete();
  endtask

  task automatic pulse_load(input int code);
    alphabet = 8'(code);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic pulse_clear(input logic [11:0] val);
    clr_value = val;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
  endtask

  task automatic stream(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      px_valid = 1'b1;
      px_data  = 12'((i % W) + 16 * (i / W));
      @(negedge clk);
      if (toggle) begin
        px_valid = 1'b0;
        px_data  = 12'hbad;
        @(negedge clk);
      end
    end
    px_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cyc < 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", (done_cyc >= 0), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load_start = 1'b0; clr_start = 1'b0; px_valid = 1'b0;
    alphabet = '0; clr_value = '0; px_data = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_px_ready", px_ready, 0);
    check("rst_state", fsm_state, ST_IDLE);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // glyph 17, continuous stream
    reset_mon();
    pulse_load(17);
    stream(64, 1'b0);
    wait_done(10);
    check("g17_count", wr_cnt, 64);
    check("g17_first_addr", first_addr, 1032);
    check("g17_first_data", first_data, 0);
    check("g17_last_addr", last_addr, 1935);
    check("g17_last_data", last_data, 12'h077);
    check("g17_done_lat", done_cyc, last_we_cyc + 1);

    // glyph 0, stalled every other cycle
    reset_mon();
    pulse_load(0);
    stream(64, 1'b1);
    wait_done(10);
    check("g0_count", wr_cnt, 64);
    check("g0_first_addr", first_addr, 0);
    check("g0_addr7", wr_addrs[7], 7);
    check("g0_addr8", wr_addrs[8], 128);
    check("g0_last_addr", last_addr, 903);

    // glyph 128 wraps to row 0
    reset_mon();
    pulse_load(128);
    stream(64, 1'b0);
    wait_done(10);
    check("g128_count", wr_cnt, 64);
    check("g128_first_addr", first_addr, 0);
    check("g128_last_addr", last_addr, 903);

    // full clear
    reset_mon();
    pulse_clear(12'hfff);
    wait_done(TOTAL + 20);
    check("clr_count", wr_cnt, TOTAL);
    check("clr_first_addr", first_addr, 0);
    check("clr_last_addr", last_addr, 8191);
    check("clr_last_data", last_data, 12'hfff);
    check("clr_done_lat", done_cyc, last_we_cyc + 1);

    // simultaneous starts: clear wins, load during clear ignored
    reset_mon();
    alphabet = 8'd3;
    clr_value = 12'ha5a;
    clr_start = 1'b1;
    load_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    load_start = 1'b0;
    repeat (5) @(negedge clk);
    pulse_load(9);
    wait_done(TOTAL + 20);
    repeat (4) @(negedge clk);
    check("both_count", wr_cnt, TOTAL);
    check("both_first_data", first_data, 12'ha5a);
    check("both_state", fsm_state, ST_IDLE);
    check("both_busy", busy, 0);

    // reset in the middle of a glyph load
    reset_mon();
    pulse_load(17);
    stream(20, 1'b0);
    rst = 1'b1;
    px_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", fsm_state, ST_IDLE);
    check("mid_rst_count", wr_cnt, 20);
    rst = 1'b0;
    px_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_mon();
    pulse_load(0);
    stream(64, 1'b0);
    wait_done(10);
    check("restart_count", wr_cnt, 64);
    check("restart_first_addr", first_addr, 0);
    check("restart_first_data", first_data, 0);
    check("restart_last_addr", last_addr, 903);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/font_mem_writer.md
Name: font_mem_writer

Overview:
- Write-side counterpart of the font memory address generator.
- Loads one glyph bitmap, streamed pixel by pixel, into the font block RAM, or bulk-clears the whole memory.
- Uses the same tiled layout as the read side, so pixel (x,y) of glyph `alphabet` lands at the address the renderer reads.
- Sits between a glyph source (UART/keyboard editor) and the write port of the dual-port font RAM.

Parameters:
- PX_ADDR_BITS_N, 13, font RAM address width.
- PX_DATA_BITS_N, 12, pixel word width (RGB444).
- FONT_WIDTH_CNT, 8, glyph width in pixels.
- FONT_HEIGHT_CNT, 8, glyph height in pixels.
- FONT_NUM_ROW, 8, glyph rows in the sheet.
- FONT_NUM_COL, 16, glyph columns in the sheet.
- ALPHABET_BITS_N, 8, glyph code width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- load_start  in  1  one-cycle pulse; begin glyph load
- alphabet  in  ALPHABET_BITS_N  glyph code, sampled with load_start
- clr_start  in  1  one-cycle pulse; begin full-memory clear
- clr_value  in  PX_DATA_BITS_N  fill word, sampled with clr_start
- px_valid  in  1  stream pixel valid
- px_data  in  PX_DATA_BITS_N  stream pixel, raster order (x fastest)
- px_ready  out  1  writer accepts a pixel this cycle
- mem_we  out  1  RAM write enable
- mem_addr  out  PX_ADDR_BITS_N  RAM write address
- mem_din  out  PX_DATA_BITS_N  RAM write data
- busy  out  1  high in LOAD or CLEAR
- done  out  1  one-cycle pulse after the last write

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; px_ready=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0; all counters 0.
- States:
  - IDLE
    - clr_start → CLEAR. clr_start has priority when it coincides with load_start.
    - load_start → LOAD.
    - Starts are ignored in every other state.
  - LOAD
    - px_ready=1 (combinational from state).
    - Transfer occurs when px_valid && px_ready. On each transfer, x++.
    - x wraps at FONT_WIDTH_CNT-1 to 0, with y++.
    - The transfer with x=W-1, y=H-1 → DONE.
    - px_valid low stalls with no write.
  - CLEAR
    - One write per cycle with a linear address 0..TOTAL-1, TOTAL = W·H·NCOL·NROW.
    - Write of TOTAL-1 → DONE.
    - px_ready=0.
  - DONE: one cycle, then → IDLE.
- Glyph placement, latched at load_start:
  - bc = alphabet % NCOL
  - br = (alphabet / NCOL) % NROW
  - Out-of-range codes wrap the row.
- Address: addr = (x + W·bc) + W·NCOL·(y + H·br), computed at full PX_ADDR_BITS_N width with no truncation before the final sum.
- Write-port latency: mem_we/mem_addr/mem_din are registered, 1 cycle after the accepting transfer (or the CLEAR counter step). mem_we=0 otherwise.
- done: pulses the cycle after the last mem_we, i.e. coincides with the DONE state registered output. busy=0 in that cycle.
- busy: combinational, high in LOAD or CLEAR.
- Reset mid-operation: the sequence is abandoned immediately and no further writes occur. Pixels already written remain in RAM.
- px_valid outside LOAD: ignored, no writes.

Decomposition:
- Shared package (global.v defines): FSM state encodings, FONT_* geometry defaults, FONT_TOTAL_PX constant.
- One natural sub-module: font_tile_addr. A combinational alphabet+(x,y)→address helper, reusable by the read side so both ends share one formula.

Test Plan:
- Geometry is the defaults: W=H=8, NCOL=16, NROW=8, TOTAL=8192.
- load_start with alphabet=17, px_valid held high, px_data=x+16·y → first write addr 1032 data 0, last write addr 1935 data 0x77; 64 writes; done one cycle after the last write.
- alphabet=0 with px_valid toggled every other cycle → 64 writes, addresses 0..7, 128..135, …, 903; no write in stalled cycles; px_ready stays 1 in LOAD.
- alphabet=128 → identical addresses to alphabet=0 (row wrap); first 0, last 903.
- clr_start with clr_value=0xFFF → 8192 consecutive writes, addr 0..8191, data 0xFFF; busy high throughout; done pulse after addr 8191.
- clr_start and load_start in the same cycle → CLEAR taken; load_start pulse during CLEAR ignored; no LOAD follows.
- rst asserted after 20 pixels of a glyph load → next cycle mem_we=0, busy=0, state IDLE; a later load_start restarts from x=y=0.
